score_scan: RTL and testbench

SCORE_SCAN -- requirements
Module: score_scan

---
 rtl/score_scan_pkg.sv | 27 ++
 rtl/score_cmp.sv | 40 ++++
 rtl/score_scan.sv | 176 +++++++++++++++++
 tb/tb_score_scan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_scan_pkg.sv
// Shared definitions for the Score_RAM scanner: FSM encoding, word field
// positions and default geometry.
package score_scan_pkg;

    localparam int DEF_ENTRIES = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_WORD_W  = 16;

    localparam int VALID_BIT = 15;
    localparam int TENS_HI   = 7;
    localparam int TENS_LO   = 4;
    localparam int ONES_HI   = 3;
    localparam int ONES_LO   = 0;
    localparam int SCORE_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

    function automatic logic bcd_ok(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/score_cmp.sv
// Qualifies one returned Score_RAM word and decides whether it beats the
// running best. Digit checking is enabled by SCORE_SCAN_BCD_CHECK_EN.
module score_cmp
    import score_scan_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic               en_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               best_vld_i,
    input  logic [SCORE_W-1:0] best_score_i,
    output logic               take_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               err_o
);

    logic valid;
    logic digits_ok;
    logic qual;
    logic unused_word_bits;

    assign score_o = {word_i[TENS_HI:TENS_LO], word_i[ONES_HI:ONES_LO]};
    assign valid   = en_i & word_i[VALID_BIT];

`ifdef SCORE_SCAN_BCD_CHECK_EN
    assign digits_ok = bcd_ok(word_i[TENS_HI:TENS_LO]) & bcd_ok(word_i[ONES_HI:ONES_LO]);
`else
    assign digits_ok = 1'b1;
`endif

    assign qual  = valid & digits_ok;
    assign err_o = valid & ~digits_ok;

    // Strictly greater only: entries arrive in ascending address order, so a
    // tie leaves the lower address in place.
    assign take_o = qual & (~best_vld_i | (score_o > best_score_i));

    assign unused_word_bits = ^word_i;

endmodule

// File: rtl/score_scan.sv
// Scans every Score_RAM entry and reports the highest valid BCD score.
// Define SCORE_SCAN_BCD_CHECK_EN to reject entries with digits above 9.
module score_scan
    import score_scan_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WORD_W  = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] scoreRAM_Addr,
    output logic              scoreRAM_RW,
    input  logic [WORD_W-1:0] scoreRAM_Dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bestAddr,
    output logic [3:0]        bestTens,
    output logic [3:0]        bestOnes,
    output logic              bestValid,
    output logic              bcdErr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               scan_clr;

    logic               cmp_vld_q;
    logic [ADDR_W-1:0]  cmp_addr_q;

    logic               run_vld_q, run_vld_d;
    logic [ADDR_W-1:0]  run_addr_q, run_addr_d;
    logic [SCORE_W-1:0] run_score_q, run_score_d;
    logic               run_err_q, run_err_d;

    logic               best_vld_q;
    logic [ADDR_W-1:0]  best_addr_q;
    logic [SCORE_W-1:0] best_score_q;
    logic               best_err_q;

    logic               take;
    logic [SCORE_W-1:0] cmp_score;
    logic               cmp_err;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy     = 1'b0;
        done     = 1'b0;
        scan_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    addr_d   = '0;
                    scan_clr = 1'b1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign scoreRAM_Addr = (state_q == SCAN) ? addr_q : '0;
    assign scoreRAM_RW   = 1'b0;

    // Read data lags the address by one cycle; track which address it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            cmp_vld_q  <= (state_q == SCAN);
            cmp_addr_q <= addr_q;
        end
    end

    score_cmp #(
        .WORD_W(WORD_W)
    ) u_cmp (
        .en_i        (cmp_vld_q),
        .word_i      (scoreRAM_Dout),
        .best_vld_i  (run_vld_q),
        .best_score_i(run_score_q),
        .take_o      (take),
        .score_o     (cmp_score),
        .err_o       (cmp_err)
    );

    always_comb begin
        run_vld_d   = run_vld_q;
        run_addr_d  = run_addr_q;
        run_score_d = run_score_q;
        run_err_d   = run_err_q;
        if (scan_clr) begin
            run_vld_d   = 1'b0;
            run_addr_d  = '0;
            run_score_d = '0;
            run_err_d   = 1'b0;
        end else begin
            if (take) begin
                run_vld_d   = 1'b1;
                run_addr_d  = cmp_addr_q;
                run_score_d = cmp_score;
            end
            if (cmp_err) begin
                run_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_vld_q   <= 1'b0;
            run_addr_q  <= '0;
            run_score_q <= '0;
            run_err_q   <= 1'b0;
        end else begin
            run_vld_q   <= run_vld_d;
            run_addr_q  <= run_addr_d;
            run_score_q <= run_score_d;
            run_err_q   <= run_err_d;
        end
    end

    // Results are captured on the DRAIN->FINISH edge, including the last
    // compare, so they are visible in the same cycle as done.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_vld_q   <= 1'b0;
            best_addr_q  <= '0;
            best_score_q <= '0;
            best_err_q   <= 1'b0;
        end else if (state_q == DRAIN) begin
            best_vld_q   <= run_vld_d;
            best_addr_q  <= run_addr_d;
            best_score_q <= run_score_d;
            best_err_q   <= run_err_d;
        end
    end

    assign bestValid = best_vld_q;
    assign bestAddr  = best_addr_q;
    assign bestTens  = best_score_q[7:4];
    assign bestOnes  = best_score_q[3:0];
    assign bcdErr    = best_err_q;

endmodule

// File: tb/tb_score_scan.sv
// Directed self-checking bench for score_scan with a behavioural Score_RAM.
module tb_score_scan;

    localparam int ENTRIES = 32;
    localparam int ADDR_W  = 5;
    localparam int WORD_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] scoreRAM_Addr;
    logic              scoreRAM_RW;
    logic [WORD_W-1:0] scoreRAM_Dout;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bestAddr;
    logic [3:0]        bestTens;
    logic [3:0]        bestOnes;
    logic              bestValid;
    logic              bcdErr;

    logic [WORD_W-1:0] mem [ENTRIES];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) scoreRAM_Dout <= mem[scoreRAM_Addr];

    score_scan #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .scoreRAM_Addr(scoreRAM_Addr), .scoreRAM_RW(scoreRAM_RW), .scoreRAM_Dout(scoreRAM_Dout),
        .busy(busy), .done(done), .bestAddr(bestAddr), .bestTens(bestTens),
        .bestOnes(bestOnes), .bestValid(bestValid), .bcdErr(bcdErr)
    );

    task automatic fill_mem(input logic [WORD_W-1:0] w);
        for (int i = 0; i < ENTRIES; i++) mem[i] = w;
    endtask

    // Runs one scan; checks the address sequence and RW each cycle; returns
    // the cycle count from the start-sampling cycle (1) to done.
    task automatic do_scan(output int lat);
        logic [ADDR_W-1:0] exp_addr;
        lat = 0;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); lat++;
            @(negedge clk); start = 1'b0;
            exp_addr = (lat >= 1 && lat <= ENTRIES) ? ADDR_W'(lat - 1) : '0;
            n_chk++;
            if (scoreRAM_Addr !== exp_addr || scoreRAM_RW !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_addr cycle %0d: got addr %0d rw %b, expected addr %0d rw 0",
                         lat, scoreRAM_Addr, scoreRAM_RW, exp_addr);
            end
            if (done === 1'b1) break;
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_timeout: done=%b after %0d cycles, expected 1", done, lat);
        end
    endtask

    task automatic check_result(input string nm, input logic [ADDR_W-1:0] ea, input logic [3:0] et,
                                input logic [3:0] eo, input logic ev, input logic ee);
        n_chk++;
        if ({bestAddr, bestTens, bestOnes, bestValid, bcdErr} !== {ea, et, eo, ev, ee}) begin
            n_fail++;
            $display("FAIL %s: got addr %0d tens %0d ones %0d valid %b err %b, expected addr %0d tens %0d ones %0d valid %b err %b",
                     nm, bestAddr, bestTens, bestOnes, bestValid, bcdErr, ea, et, eo, ev, ee);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, scoreRAM_Addr, scoreRAM_RW} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy %b done %b addr %0d rw %b, expected all 0",
                     busy, done, scoreRAM_Addr, scoreRAM_RW);
        end
        check_result("reset_result", 5'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy %b done %b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_all_invalid();
        int lat;
        fill_mem(16'h0099);
        mem[5] = 16'h7F55;
        do_scan(lat);
        n_chk++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL invalid_latency: got %0d, expected 34", lat);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_busy: got %b, expected 0", busy);
        end
        check_result("all_invalid", 5'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_two_valid();
        int lat;
        fill_mem(16'h0000);
        mem[7]  = 16'hFF42;
        mem[20] = 16'h8087;
        mem[25] = 16'h0099;
        do_scan(lat);
        check_result("two_valid", 5'd20, 4'd8, 4'd7, 1'b1, 1'b0);
    endtask

    task automatic test_tie();
        int lat;
        fill_mem(16'h0000);
        mem[3]  = 16'h8055;
        mem[9]  = 16'h8055;
        mem[12] = 16'h8054;
        do_scan(lat);
        check_result("tie_lower", 5'd3, 4'd5, 4'd5, 1'b1, 1'b0);
    endtask

    task automatic test_last_entry();
        int lat;
        fill_mem(16'h0000);
        mem[0]  = 16'h8000;
        mem[31] = 16'h8099;
        do_scan(lat);
        n_chk++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL last_latency: got %0d, expected 34", lat);
        end
        check_result("last_entry", 5'd31, 4'd9, 4'd9, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        int c = 0;
        int dones = 0;
        fill_mem(16'h0000);
        mem[7] = 16'h8042;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); c++;
            @(negedge clk);
            start = (c == 5 || c == 20);
            if (done === 1'b1) dones++;
            if (c == 10) check_result("hold_mid_scan", 5'd31, 4'd9, 4'd9, 1'b1, 1'b0);
        end
        start = 1'b0;
        n_chk++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %0d done pulses, expected 1", dones);
        end
        check_result("busy_start_result", 5'd7, 4'd4, 4'd2, 1'b1, 1'b0);
    endtask

    task automatic test_finish_start();
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) break;
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL finish_reach: done=%b, expected 1", done);
        end
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_start_ignored: got busy %b done %b, expected 0 0", busy, done);
        end
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || scoreRAM_Addr !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_start_accept: got busy %b addr %0d, expected 1 0", busy, scoreRAM_Addr);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) break;
        end
        check_result("finish_start_result", 5'd7, 4'd4, 4'd2, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        int dones = 0;
        int lat;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); c++;
            @(negedge clk);
            start = 1'b0;
            rst = (c == 15);
            if (done === 1'b1) dones++;
        end
        rst = 1'b0;
        n_chk++;
        if (dones !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d done pulses busy %b, expected 0 0", dones, busy);
        end
        check_result("reset_abort_result", 5'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        fill_mem(16'h0000);
        mem[31] = 16'h8099;
        do_scan(lat);
        n_chk++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d, expected 34", lat);
        end
        check_result("restart_result", 5'd31, 4'd9, 4'd9, 1'b1, 1'b0);
    endtask

    task automatic test_bcd();
        int lat;
        fill_mem(16'h0000);
        mem[4] = 16'h80A3;
        mem[6] = 16'h8012;
        do_scan(lat);
`ifdef SCORE_SCAN_BCD_CHECK_EN
        check_result("bcd_check", 5'd6, 4'd1, 4'd2, 1'b1, 1'b1);
`else
        check_result("bcd_nocheck", 5'd4, 4'hA, 4'd3, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fill_mem(16'h0000);
        test_reset();
        test_all_invalid();
        test_two_valid();
        test_tie();
        test_last_entry();
        test_start_ignored();
        test_finish_start();
        test_reset_mid();
        test_bcd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
